// File: rtl/mem_resp_ctrl.sv
// mem_resp_ctrl: responder for the memory-stage data interface.
// Takes one load/store at a time and moves it over an 8-bit single-port RAM
// bus, one byte per cycle, little-endian. Load results are assembled and
// optionally sign-extended, then returned with a one-cycle resp_valid pulse.
// Optional feature macro: MEM_RESP_MISALIGN_ERR_EN adds resp_err and rejects
// misaligned half/word requests without touching the RAM.
module mem_resp_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
`ifdef MEM_RESP_MISALIGN_ERR_EN
    output logic              resp_err,
`endif
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    state_t              r_state;
    state_t              r_state_next;
    logic                r_we;
    logic                r_sext;
    logic [1:0]          r_last;     // index of the final byte (N-1)
    logic [2:0]          r_k;        // byte index being issued; reaches N in DRAIN
    logic [ADDR_W-1:0]   r_mem_a;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_data;

    logic                w_accept;
    logic                w_misalign;
    logic                w_err;
    logic [1:0]          w_req_last;
    logic [1:0]          w_cap_idx;
    logic                w_sign;
    logic [DATA_W-1:0]   w_rdata;

    assign w_accept   = req_valid && req_ready && rdy;
    assign w_req_last = (req_size == 2'd0) ? 2'd0 : (req_size == 2'd1) ? 2'd1 : 2'd3;
    // Read data lags the issued address by one cycle, so the byte captured
    // now belongs to the previous index (r_k-1, wrapping 4 -> 3 in DRAIN).
    assign w_cap_idx  = r_k[1:0] - 2'd1;

`ifdef MEM_RESP_MISALIGN_ERR_EN
    assign w_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // State register; a low rdy freezes the whole block.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else if (rdy)
            r_state <= r_state_next;
    end

    // Next-state and control outputs.
    always_comb begin
        r_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_wr       = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    r_state_next = w_misalign ? DONE : XFER;
            end
            XFER: begin
                // Gating by rst keeps an aborted store from landing one more byte.
                mem_wr = r_we && rdy && !rst;
                if (r_k[1:0] == r_last)
                    r_state_next = r_we ? DONE : DRAIN;
            end
            DRAIN: begin
                r_state_next = DONE;
            end
            DONE: begin
                req_ready  = 1'b1;
                resp_valid = 1'b1;
                if (req_valid)
                    r_state_next = w_misalign ? DONE : XFER;
                else
                    r_state_next = IDLE;
            end
            default: r_state_next = IDLE;
        endcase
    end

    // Request latch, byte counter, RAM address and load-byte capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_sext  <= 1'b0;
            r_last  <= 2'd0;
            r_k     <= 3'd0;
            r_mem_a <= '0;
            r_wdata <= '0;
            r_data  <= '0;
        end else if (rdy) begin
            if (w_accept) begin
                r_we    <= req_we;
                r_sext  <= req_sext;
                r_last  <= w_req_last;
                r_wdata <= req_wdata;
                r_mem_a <= req_addr;
                r_k     <= 3'd0;
                r_data  <= '0;
            end else if (r_state == XFER) begin
                r_k <= r_k + 3'd1;
                // Address stays on the last byte so mem_a holds once idle.
                if (r_k[1:0] != r_last)
                    r_mem_a <= r_mem_a + ADDR_W'(1);
                if (!r_we && (r_k != 3'd0))
                    r_data[{w_cap_idx, 3'b000} +: 8] <= mem_din;
            end else if (r_state == DRAIN) begin
                r_data[{w_cap_idx, 3'b000} +: 8] <= mem_din;
            end
        end
    end

`ifdef MEM_RESP_MISALIGN_ERR_EN
    logic r_err;

    // Remember whether the accepted request was rejected as misaligned.
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (rdy && w_accept)
            r_err <= w_misalign;
    end

    assign w_err    = r_err;
    assign resp_err = (r_state == DONE) && r_err;
`else
    assign w_err = 1'b0;
`endif

    // Sign bit is the top bit of the last loaded byte.
    assign w_sign = r_data[{r_last, 3'b111}];

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_byte
            assign w_rdata[gi*8 +: 8] = (2'(gi) <= r_last) ? r_data[gi*8 +: 8] :
                                        ((r_sext && w_sign) ? 8'hFF : 8'h00);
        end
    endgenerate

    assign resp_rdata = ((r_state == DONE) && !r_we && !w_err) ? w_rdata : '0;
    assign mem_a      = r_mem_a;
    assign mem_dout   = ((r_state == XFER) && r_we) ? r_wdata[{r_k[1:0], 3'b000} +: 8] : 8'h00;

endmodule
